// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: reset PC default, fetch FSM encoding and buffered entry layout
package pc_fetch_unit_pkg;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
   typedef enum logic [1:0] {FS_REQ = 2'd0, FS_WAIT = 2'd1, FS_DROP = 2'd2} fetch_state_e;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;
   function automatic logic [31:0] align_word(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction
endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: redirect, instruction-memory and decode-side signals of the fetch unit
interface pc_fetch_unit_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_ready;
   logic        addr_err;
   modport master (
      input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
      output imem_req, imem_addr, out_valid, out_pc, out_instr, addr_err
   );
   modport slave (
      output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
      input  imem_req, imem_addr, out_valid, out_pc, out_instr, addr_err
   );
endinterface

// File: rtl/pc_fetch_unit_fetch_fifo.sv
// fetch_fifo: power-of-two instruction buffer with push/pop/flush and a combinational head
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int W = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   input  logic [W-1:0]               data_i,
   output logic [W-1:0]               head_o,
   output logic [$clog2(DEPTH):0]     count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb begin
      rd_d  = flush_i ? '0 : rd_q + AW'(pop_i);
      wr_d  = flush_i ? '0 : wr_q + AW'(push_i);
      cnt_d = flush_i ? '0 : cnt_q + CW'(push_i) - CW'(pop_i);
   end
   always_ff @(posedge clk)
      if (push_i && !flush_i) mem_q[wr_q] <= data_i;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   assign head_o  = mem_q[rd_q];
   assign count_o = cnt_q;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: fetch PC, single-outstanding imem fetch FSM and decode-facing instruction buffer
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          BUF_DEPTH = 2
) (
   input logic             clk,
   input logic             rst,
   pc_fetch_unit_if.master bus
);
   localparam int CW = $clog2(BUF_DEPTH) + 1;
   fetch_state_e  state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
   logic          addr_err_q, addr_err_d;
   logic          req, fire, push, pop;
   logic [CW-1:0] count;
   fetch_entry_t  head;
   always_ff @(posedge clk or posedge rst)
      if (rst) state_q <= FS_REQ;
      else     state_q <= state_d;
   // a redirect while waiting must still absorb the in-flight response, hence DROP
   always_comb begin
      state_d = state_q;
      case (state_q)
         FS_REQ:  state_d = fire ? FS_WAIT : FS_REQ;
         FS_WAIT: state_d = bus.imem_rvalid ? FS_REQ : (bus.redirect_valid ? FS_DROP : FS_WAIT);
         FS_DROP: state_d = bus.imem_rvalid ? FS_REQ : FS_DROP;
         default: state_d = FS_REQ;
      endcase
   end
   always_comb begin
      req  = !rst && (state_q == FS_REQ) && (count < CW'(BUF_DEPTH)) && !bus.redirect_valid;
      fire = req && bus.imem_gnt;
      push = (state_q == FS_WAIT) && bus.imem_rvalid && !bus.redirect_valid;
      pop  = bus.out_valid && bus.out_ready && !bus.redirect_valid;
   end
   always_comb begin
      fetch_pc_d = bus.redirect_valid ? align_word(bus.redirect_pc) : (fire ? fetch_pc_q + 32'd4 : fetch_pc_q);
      req_pc_d   = fire ? fetch_pc_q : req_pc_q;
      addr_err_d = addr_err_q | (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00));
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
         addr_err_q <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         addr_err_q <= addr_err_d;
      end
   fetch_fifo #(.DEPTH(BUF_DEPTH), .W(64)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (bus.redirect_valid),
      .data_i  ({req_pc_q, bus.imem_rdata}),
      .head_o  (head),
      .count_o (count)
   );
   assign bus.imem_req  = req;
   assign bus.imem_addr = fetch_pc_q;
   assign bus.out_valid = (count != '0);
   assign bus.out_pc    = head.pc;
   assign bus.out_instr = head.instr;
   assign bus.addr_err  = addr_err_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed plan steps plus randomized traffic checked against a fetch-stream model
module tb_pc_fetch_unit;
   localparam logic [31:0] RST_PC = 32'h0000_3000;
   logic        clk = 1'b0;
   logic        rst;
   int          errors = 0;
   int          checks = 0;
   bit          pend;
   logic [31:0] pend_addr;
   int          pend_lat;
   bit          gnt_k, ready_k;
   int          lat_k;
   logic [31:0] exp_fetch, exp_out;
   bit          exp_err;
   logic [31:0] fired[$];
   logic [31:0] popped[$];
   pc_fetch_unit_if bus();
   pc_fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #10 clk = ~clk;
   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_0F0F;
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
   endtask
   // One clock of traffic: the bench acts as memory (one pending request) and predicts
   // the fetch address stream and the decode stream as contiguous runs restarted by redirects.
   task automatic cyc(input bit redir, input logic [31:0] rpc);
      bit pend0, rv, fire, take;
      pend0 = pend;
      rv = pend && (pend_lat == 0);
      bus.redirect_valid = redir;
      bus.redirect_pc    = rpc;
      bus.imem_gnt       = gnt_k;
      bus.out_ready      = ready_k;
      bus.imem_rvalid    = rv;
      bus.imem_rdata     = rv ? mem(pend_addr) : 32'h0;
      #2;
      chk("addr_err", 32'(bus.addr_err), 32'(exp_err));
      if (redir) chk("req_during_redirect", 32'(bus.imem_req), 32'd0);
      fire = bus.imem_req && gnt_k;
      take = bus.out_valid && ready_k && !redir;
      if (fire) begin
         chk("single_outstanding", 32'(pend0), 32'd0);
         chk("fetch_addr", bus.imem_addr, exp_fetch);
         fired.push_back(bus.imem_addr);
         exp_fetch += 4;
      end
      if (take) begin
         chk("out_pc", bus.out_pc, exp_out);
         chk("out_instr", bus.out_instr, mem(exp_out));
         popped.push_back(bus.out_pc);
         exp_out += 4;
      end
      if (redir) begin
         exp_fetch = {rpc[31:2], 2'b00};
         exp_out   = {rpc[31:2], 2'b00};
         exp_err   = exp_err | (rpc[1:0] != 2'b00);
      end
      if (rv) pend = 1'b0;
      else if (pend) pend_lat--;
      if (fire) begin
         pend      = 1'b1;
         pend_addr = bus.imem_addr;
         pend_lat  = lat_k;
      end
      @(posedge clk);
      #1;
   endtask
   initial begin
      int          n;
      logic [31:0] t;
      rst = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.imem_gnt       = 1'b0;
      bus.imem_rvalid    = 1'b0;
      bus.imem_rdata     = 32'h0;
      bus.out_ready      = 1'b0;
      pend = 1'b0; pend_addr = 32'h0; pend_lat = 0;
      gnt_k = 1'b1; ready_k = 1'b1; lat_k = 0;
      exp_fetch = RST_PC; exp_out = RST_PC; exp_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", 32'(bus.imem_req), 32'd0);
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_err", 32'(bus.addr_err), 32'd0);
      rst = 1'b0;
      // sequential fetch with immediate grant and 1-cycle response
      repeat (8) cyc(1'b0, 32'h0);
      chk("seq_addr0", fired[0], 32'h3000);
      chk("seq_addr1", fired[1], 32'h3004);
      chk("seq_addr2", fired[2], 32'h3008);
      chk("seq_out0", popped[0], 32'h3000);
      chk("seq_out1", popped[1], 32'h3004);
      // decode back-pressure fills the buffer and stalls fetch
      ready_k = 1'b0;
      repeat (10) cyc(1'b0, 32'h0);
      chk("full_no_req", 32'(bus.imem_req), 32'd0);
      chk("full_valid", 32'(bus.out_valid), 32'd1);
      gnt_k = 1'b0; ready_k = 1'b1;
      n = popped.size();
      repeat (6) cyc(1'b0, 32'h0);
      chk("drain_count", 32'(popped.size() - n), 32'd2);
      chk("held_req", 32'(bus.imem_req), 32'd1);
      chk("held_addr", bus.imem_addr, exp_fetch);
      gnt_k = 1'b1;
      // redirect while waiting on a slow response
      lat_k = 3;
      n = fired.size();
      for (int i = 0; i < 10 && fired.size() == n; i++) cyc(1'b0, 32'h0);
      chk("wait_fired", 32'(fired.size() - n), 32'd1);
      lat_k = 0;
      cyc(1'b1, 32'h3400);
      n = fired.size();
      for (int i = 0; i < 12 && fired.size() == n; i++) cyc(1'b0, 32'h0);
      chk("wait_redirect_target", (fired.size() > n) ? fired[n] : 32'h0, 32'h3400);
      // redirect coinciding with the response
      lat_k = 1;
      n = fired.size();
      for (int i = 0; i < 10 && fired.size() == n; i++) cyc(1'b0, 32'h0);
      cyc(1'b0, 32'h0);
      cyc(1'b1, 32'h5000);
      bus.redirect_valid = 1'b0; bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0;
      #1;
      chk("same_cycle_empty", 32'(bus.out_valid), 32'd0);
      chk("same_cycle_req", 32'(bus.imem_req), 32'd1);
      chk("same_cycle_addr", bus.imem_addr, 32'h5000);
      lat_k = 0;
      // misaligned redirect target
      repeat (3) cyc(1'b0, 32'h0);
      cyc(1'b1, 32'h0000_3402);
      chk("misalign_err", 32'(bus.addr_err), 32'd1);
      n = fired.size();
      for (int i = 0; i < 12 && fired.size() == n; i++) cyc(1'b0, 32'h0);
      chk("misalign_target", (fired.size() > n) ? fired[n] : 32'h0, 32'h3400);
      repeat (5) cyc(1'b0, 32'h0);
      chk("misalign_sticky", 32'(bus.addr_err), 32'd1);
      // reset in the middle of a slow fetch with a buffered entry
      ready_k = 1'b0;
      cyc(1'b1, 32'h7000);
      n = fired.size();
      for (int i = 0; i < 12 && fired.size() == n; i++) cyc(1'b0, 32'h0);
      cyc(1'b0, 32'h0);
      lat_k = 6;
      n = fired.size();
      for (int i = 0; i < 6 && fired.size() == n; i++) cyc(1'b0, 32'h0);
      chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_req", 32'(bus.imem_req), 32'd0);
      chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_err", 32'(bus.addr_err), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_fetch = RST_PC; exp_out = RST_PC; exp_err = 1'b0;
      gnt_k = 1'b0; ready_k = 1'b1; lat_k = 0;
      #1;
      chk("post_rst_req", 32'(bus.imem_req), 32'd1);
      chk("post_rst_addr", bus.imem_addr, 32'h3000);
      for (int i = 0; i < 12 && pend; i++) cyc(1'b0, 32'h0);
      chk("late_resp_pending", 32'(pend), 32'd0);
      chk("late_resp_ignored", 32'(bus.out_valid), 32'd0);
      gnt_k = 1'b1;
      n = popped.size();
      repeat (10) cyc(1'b0, 32'h0);
      chk("post_rst_first_out", (popped.size() > n) ? popped[n] : 32'h0, 32'h3000);
      // randomized traffic including address wrap-around
      for (int i = 0; i < 800; i++) begin
         gnt_k   = ($urandom_range(0, 9) < 7);
         ready_k = ($urandom_range(0, 9) < 6);
         lat_k   = $urandom_range(0, 3);
         if ($urandom_range(0, 99) < 6) begin
            t = $urandom & 32'h0003_FFFF;
            if ($urandom_range(0, 9) != 0) t[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF8;
            cyc(1'b1, t);
         end else begin
            cyc(1'b0, 32'h0);
         end
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
